pipe_control: RTL and testbench

//  Pipelined successor of the single-cycle decoder: decodes the ID-stage opcode into a control bundle.

---
 rtl/pipe_pkg.sv | 52 +++++
 rtl/pipe_hazard_unit.sv | 56 +++++
 rtl/pipe_control.sv | 177 +++++++++++++++++
 tb/tb_pipe_control.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared control types, opcode constants and RAW-match helper for the pipelined ARMv8 control path.
// No logic of its own; latency and backpressure are defined by the pipe_* modules that import it.
// Imported by pipe_hazard_unit and pipe_control.
package pipe_pkg;

    localparam int OPC_W   = 11;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 2;

    localparam logic [REG_AW-1:0] ZR_IDX = 5'd31;

    localparam logic [ALUOP_W-1:0] ALUOP_MEM   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_LSL  = 11'b11010011011;
    localparam logic [OPC_W-1:0] OPC_LSR  = 11'b11010011010;
    // CBZ and B carry immediate bits in the low opcode field; only the fixed prefix decodes.
    localparam logic [7:0] OPC_CBZ_HI = 8'b10110100;
    localparam logic [5:0] OPC_B_HI   = 6'b000101;

    typedef struct packed {
        logic               reg2loc;
        logic               alu_src;
        logic [ALUOP_W-1:0] aluop;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               ubranch;
        logic               reg_write;
        logic               mem2reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rd;
    } stage_t;

    function automatic logic raw_match(input logic [REG_AW-1:0] src, input logic used,
                                       input logic [REG_AW-1:0] rd, input logic wr);
        return used && wr && (src == rd) && (rd != ZR_IDX);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// RAW hazard detection: stall request and, with PIPE_FWD_EN, EX-stage forward selects.
// Purely combinational, zero latency.
// Stall is the only backpressure; with PIPE_FWD_EN only load-use stalls.
module pipe_hazard_unit
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm2,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
`ifdef PIPE_FWD_EN
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rn,
    input  logic [REG_AW-1:0] ex_rm2,
    input  logic              ex_use_rn,
    input  logic              ex_use_rm,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`endif
    output logic              stall
);

    logic id_dep_ex;
    assign id_dep_ex = raw_match(id_rn, id_use_rn, ex_rd, ex_reg_write)
                    || raw_match(id_rm2, id_use_rm, ex_rd, ex_reg_write);

`ifdef PIPE_FWD_EN
    assign stall = ex_mem_read && id_dep_ex;

    // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (raw_match(ex_rn, ex_use_rn, mem_rd, mem_reg_write))
            fwd_a = 2'b10;
        else if (raw_match(ex_rn, ex_use_rn, wb_rd, wb_reg_write))
            fwd_a = 2'b01;
        if (raw_match(ex_rm2, ex_use_rm, mem_rd, mem_reg_write))
            fwd_b = 2'b10;
        else if (raw_match(ex_rm2, ex_use_rm, wb_rd, wb_reg_write))
            fwd_b = 2'b01;
    end
`else
    // MEM/WB is not checked: the regfile writes in the first half-cycle, reads in the second.
    assign stall = id_dep_ex
                || raw_match(id_rn, id_use_rn, mem_rd, mem_reg_write)
                || raw_match(id_rm2, id_use_rm, mem_rd, mem_reg_write);
`endif

endmodule

// File: rtl/pipe_control.sv
// ID-stage decode plus ID/EX, EX/MEM, MEM/WB control registers and stall/flush control (PIPE_FWD_EN adds forwarding).
// Decode and pc_write/ifid_write are combinational; each stage register adds one cycle.
// Stalls hold PC and IF/ID and inject one bubble per stalled cycle; flush overrides stall.
module pipe_control
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [REG_AW-1:0]  id_rn,
    input  logic [REG_AW-1:0]  id_rm,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               flush,
    output logic               reg2loc,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_branch,
    output logic               mem_ubranch,
    output logic               wb_reg_write,
    output logic               wb_mem2reg,
    output logic [REG_AW-1:0]  wb_rd
`ifdef PIPE_FWD_EN
    ,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
`endif
);

    ctrl_t             dec;
    logic              dec_known;
    logic              use_rn;
    logic              use_rm;
    logic [REG_AW-1:0] src2;
    logic              stall;
    stage_t            id_stage;
    stage_t            idex;
    stage_t            exmem;
    stage_t            memwb;

    always_comb begin
        dec       = CTRL_NOP;
        dec_known = 1'b1;
        use_rn    = 1'b0;
        use_rm    = 1'b0;
        casez (id_opcode)
            OPC_LDUR: begin
                dec.alu_src   = 1'b1;
                dec.mem2reg   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.aluop     = ALUOP_MEM;
                use_rn        = 1'b1;
            end
            OPC_STUR: begin
                dec.reg2loc   = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.aluop     = ALUOP_MEM;
                use_rn        = 1'b1;
                use_rm        = 1'b1;
            end
            {OPC_CBZ_HI, 3'b???}: begin
                dec.reg2loc = 1'b1;
                dec.branch  = 1'b1;
                dec.aluop   = ALUOP_CBZ;
                use_rm      = 1'b1;
            end
            {OPC_B_HI, 5'b?????}: begin
                dec.ubranch = 1'b1;
            end
            OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_LSL, OPC_LSR: begin
                dec.reg_write = 1'b1;
                dec.aluop     = ALUOP_RTYPE;
                use_rn        = 1'b1;
                use_rm        = 1'b1;
            end
            default: dec_known = 1'b0;
        endcase
        if (!id_valid) begin
            dec       = CTRL_NOP;
            dec_known = 1'b0;
            use_rn    = 1'b0;
            use_rm    = 1'b0;
        end
    end

    assign reg2loc = dec.reg2loc;
    assign src2    = dec.reg2loc ? id_rd : id_rm;

    // Bubbles carry rd = 0 so a dead slot never looks like a writer.
    always_comb begin
        id_stage.ctrl = dec;
        id_stage.rd   = dec_known ? id_rd : '0;
    end

`ifdef PIPE_FWD_EN
    logic [REG_AW-1:0] idex_rn;
    logic [REG_AW-1:0] idex_rm2;
    logic              idex_use_rn;
    logic              idex_use_rm;

    always_ff @(posedge clk) begin
        if (reset || flush || stall) begin
            idex_rn     <= '0;
            idex_rm2    <= '0;
            idex_use_rn <= 1'b0;
            idex_use_rm <= 1'b0;
        end else begin
            idex_rn     <= id_rn;
            idex_rm2    <= src2;
            idex_use_rn <= use_rn;
            idex_use_rm <= use_rm;
        end
    end
`endif

    pipe_hazard_unit u_hazard (
        .id_rn         (id_rn),
        .id_rm2        (src2),
        .id_use_rn     (use_rn),
        .id_use_rm     (use_rm),
        .ex_rd         (idex.rd),
        .ex_reg_write  (idex.ctrl.reg_write),
        .mem_rd        (exmem.rd),
        .mem_reg_write (exmem.ctrl.reg_write),
`ifdef PIPE_FWD_EN
        .ex_mem_read   (idex.ctrl.mem_read),
        .ex_rn         (idex_rn),
        .ex_rm2        (idex_rm2),
        .ex_use_rn     (idex_use_rn),
        .ex_use_rm     (idex_use_rm),
        .wb_rd         (memwb.rd),
        .wb_reg_write  (memwb.ctrl.reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
`endif
        .stall         (stall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            memwb <= exmem;
            exmem <= flush ? '0 : idex;
            idex  <= (flush || stall) ? '0 : id_stage;
        end
    end

    assign pc_write   = reset || flush || !stall;
    assign ifid_write = reset || flush || !stall;

    assign ex_alu_src   = idex.ctrl.alu_src;
    assign ex_aluop     = idex.ctrl.aluop;
    assign ex_rd        = idex.rd;
    assign mem_read     = exmem.ctrl.mem_read;
    assign mem_write    = exmem.ctrl.mem_write;
    assign mem_branch   = exmem.ctrl.branch;
    assign mem_ubranch  = exmem.ctrl.ubranch;
    assign wb_reg_write = memwb.ctrl.reg_write;
    assign wb_mem2reg   = memwb.ctrl.mem2reg;
    assign wb_rd        = memwb.rd;

    logic unused_wb_ctrl;
    assign unused_wb_ctrl = ^{memwb.ctrl.reg2loc, memwb.ctrl.alu_src, memwb.ctrl.aluop,
                              memwb.ctrl.mem_read, memwb.ctrl.mem_write,
                              memwb.ctrl.branch, memwb.ctrl.ubranch};

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: instruction-level reference model, directed hazard cases then random traffic.
module tb_pipe_control;

    logic        clk = 1'b0;
    logic        reset, id_valid, flush;
    logic [10:0] id_opcode;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        reg2loc, pc_write, ifid_write, ex_alu_src;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rd;
    logic        mem_read, mem_write, mem_branch, mem_ubranch;
    logic        wb_reg_write, wb_mem2reg;
    logic [4:0]  wb_rd;
`ifdef PIPE_FWD_EN
    logic [1:0]  fwd_a, fwd_b;
`endif

    always #5 clk = ~clk;

    pipe_control dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .flush(flush),
        .reg2loc(reg2loc), .pc_write(pc_write), .ifid_write(ifid_write),
        .ex_alu_src(ex_alu_src), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_branch(mem_branch),
        .mem_ubranch(mem_ubranch), .wb_reg_write(wb_reg_write),
        .wb_mem2reg(wb_mem2reg), .wb_rd(wb_rd)
`ifdef PIPE_FWD_EN
        , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
    );

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] BR   = 11'b00010110011;
    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] ANDI = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LSL  = 11'b11010011011;
    localparam logic [10:0] LSR  = 11'b11010011010;
    localparam logic [10:0] BAD  = 11'b11111111111;

    typedef enum int {K_NOP, K_LDUR, K_STUR, K_CBZ, K_B, K_RTYPE} kind_t;
    typedef struct { kind_t k; int rd; int rn; int rm2; } slot_t;
    typedef struct packed {
        logic       pc_write, ifid_write, reg2loc, ex_alu_src;
        logic [1:0] ex_aluop;
        logic [4:0] ex_rd;
        logic       mem_read, mem_write, mem_branch, mem_ubranch, wb_reg_write, wb_mem2reg;
        logic [4:0] wb_rd;
        logic [1:0] fwd_a, fwd_b;
    } exp_t;

    exp_t  q[$];
    slot_t s_ex, s_mem, s_wb;
    slot_t nop_slot = '{K_NOP, 0, 0, 0};
    int    n_vec = 0;
    int    n_bad = 0;

    function automatic kind_t classify(input logic [10:0] op);
        if (op == LDUR) return K_LDUR;
        if (op == STUR) return K_STUR;
        if (op[10:3] == 8'b10110100) return K_CBZ;
        if (op[10:5] == 6'b000101) return K_B;
        if (op == ADD || op == SUB || op == ANDI || op == ORR || op == LSL || op == LSR)
            return K_RTYPE;
        return K_NOP;
    endfunction

    function automatic bit reads_rn(input kind_t k);
        return k == K_LDUR || k == K_STUR || k == K_RTYPE;
    endfunction
    function automatic bit reads_rm(input kind_t k);
        return k == K_STUR || k == K_CBZ || k == K_RTYPE;
    endfunction
    function automatic bit writes(input kind_t k);
        return k == K_LDUR || k == K_RTYPE;
    endfunction
    function automatic bit dep(input int src, input bit used, input slot_t w);
        return used && writes(w.k) && w.rd == src && src != 31;
    endfunction

    function automatic slot_t make_slot(input bit v, input logic [10:0] op, input int rn, input int rm, input int rd);
        slot_t s;
        s = nop_slot;
        s.k = v ? classify(op) : K_NOP;
        if (s.k != K_NOP) begin
            s.rd  = rd;
            s.rn  = rn;
            s.rm2 = (s.k == K_STUR || s.k == K_CBZ) ? rd : rm;
        end
        return s;
    endfunction

    function automatic bit needs_stall(input slot_t id);
        bit on_ex, on_mem;
        on_ex  = dep(id.rn, reads_rn(id.k), s_ex)  || dep(id.rm2, reads_rm(id.k), s_ex);
        on_mem = dep(id.rn, reads_rn(id.k), s_mem) || dep(id.rm2, reads_rm(id.k), s_mem);
`ifdef PIPE_FWD_EN
        return s_ex.k == K_LDUR && on_ex;
`else
        return on_ex || on_mem;
`endif
    endfunction

    function automatic logic [1:0] fwd_for(input int src, input bit used);
        if (dep(src, used, s_mem)) return 2'b10;
        if (dep(src, used, s_wb))  return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit v, input bit f, input logic [10:0] op,
                         input int rn, input int rm, input int rd, output bit held);
        slot_t id;
        bit    st;
        exp_t  e;
        reset = r; id_valid = v; flush = f; id_opcode = op;
        id_rn = 5'(rn); id_rm = 5'(rm); id_rd = 5'(rd);
        id = make_slot(v, op, rn, rm, rd);
        st = needs_stall(id);
        e.pc_write     = r || f || !st;
        e.ifid_write   = r || f || !st;
        e.reg2loc      = id.k == K_STUR || id.k == K_CBZ;
        e.ex_alu_src   = s_ex.k == K_LDUR || s_ex.k == K_STUR;
        e.ex_aluop     = (s_ex.k == K_RTYPE) ? 2'b10 : (s_ex.k == K_CBZ) ? 2'b01 : 2'b00;
        e.ex_rd        = 5'(s_ex.rd);
        e.mem_read     = s_mem.k == K_LDUR;
        e.mem_write    = s_mem.k == K_STUR;
        e.mem_branch   = s_mem.k == K_CBZ;
        e.mem_ubranch  = s_mem.k == K_B;
        e.wb_reg_write = writes(s_wb.k);
        e.wb_mem2reg   = s_wb.k == K_LDUR;
        e.wb_rd        = 5'(s_wb.rd);
        e.fwd_a        = fwd_for(s_ex.rn, reads_rn(s_ex.k));
        e.fwd_b        = fwd_for(s_ex.rm2, reads_rm(s_ex.k));
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            s_ex = nop_slot; s_mem = nop_slot; s_wb = nop_slot;
        end else begin
            s_wb  = s_mem;
            s_mem = f ? nop_slot : s_ex;
            s_ex  = (f || st) ? nop_slot : id;
        end
        #1;
        held = !e.ifid_write;
    endtask

    task automatic idle(input int n);
        bit h;
        for (int i = 0; i < n; i++) apply(0, 0, 0, 11'd0, 0, 0, 0, h);
    endtask

    function automatic logic [10:0] rand_op();
        case ($urandom_range(0, 10))
            0: return LDUR;
            1: return STUR;
            2: return {8'b10110100, 3'($urandom_range(0, 7))};
            3: return {6'b000101, 5'($urandom_range(0, 31))};
            4: return ADD;
            5: return SUB;
            6: return ANDI;
            7: return ORR;
            8: return LSL;
            9: return LSR;
            default: return 11'($urandom);
        endcase
    endfunction

    function automatic int rand_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 31 : r + 1;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_write",     32'(pc_write),     32'(e.pc_write));
                chk("ifid_write",   32'(ifid_write),   32'(e.ifid_write));
                chk("reg2loc",      32'(reg2loc),      32'(e.reg2loc));
                chk("ex_alu_src",   32'(ex_alu_src),   32'(e.ex_alu_src));
                chk("ex_aluop",     32'(ex_aluop),     32'(e.ex_aluop));
                chk("ex_rd",        32'(ex_rd),        32'(e.ex_rd));
                chk("mem_read",     32'(mem_read),     32'(e.mem_read));
                chk("mem_write",    32'(mem_write),    32'(e.mem_write));
                chk("mem_branch",   32'(mem_branch),   32'(e.mem_branch));
                chk("mem_ubranch",  32'(mem_ubranch),  32'(e.mem_ubranch));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.wb_reg_write));
                chk("wb_mem2reg",   32'(wb_mem2reg),   32'(e.wb_mem2reg));
                chk("wb_rd",        32'(wb_rd),        32'(e.wb_rd));
`ifdef PIPE_FWD_EN
                chk("fwd_a",        32'(fwd_a),        32'(e.fwd_a));
                chk("fwd_b",        32'(fwd_b),        32'(e.fwd_b));
`endif
            end
        end
    end

    initial begin
        bit          h;
        bit          hold;
        bit          r, f, v;
        logic [10:0] op;
        int          rn, rm, rd;
        reset = 1'b1; id_valid = 1'b0; flush = 1'b0; id_opcode = '0;
        id_rn = '0; id_rm = '0; id_rd = '0;
        @(posedge clk);
        #1;
        s_ex = nop_slot; s_mem = nop_slot; s_wb = nop_slot;

        // load-use: LDUR X1,[X2]; ADD X3,X1,X4 (ADD held while stalled)
        apply(0, 1, 0, LDUR, 2, 0, 1, h);
        apply(0, 1, 0, ADD, 1, 4, 3, h);
        apply(0, 1, 0, ADD, 1, 4, 3, h);
        apply(0, 1, 0, ADD, 1, 4, 3, h);
        idle(4);
        // ALU-ALU: ADD X1,X2,X3; SUB X4,X1,X1
        apply(0, 1, 0, ADD, 2, 3, 1, h);
        for (int i = 0; i < 3; i++) apply(0, 1, 0, SUB, 1, 1, 4, h);
        idle(4);
        // XZR destination never a hazard
        apply(0, 1, 0, LDUR, 2, 0, 31, h);
        apply(0, 1, 0, ADD, 31, 4, 3, h);
        idle(4);
        // flush during a load-use stall, CBZ older in flight
        apply(0, 1, 0, CBZ, 0, 0, 5, h);
        apply(0, 1, 0, LDUR, 2, 0, 1, h);
        apply(0, 1, 1, ADD, 1, 4, 3, h);
        idle(4);
        // STUR and CBZ read rd through reg2loc
        apply(0, 1, 0, ADD, 2, 3, 6, h);
        apply(0, 1, 0, STUR, 2, 9, 6, h);
        apply(0, 1, 0, STUR, 2, 9, 6, h);
        apply(0, 1, 0, LDUR, 2, 0, 7, h);
        apply(0, 1, 0, CBZ, 0, 0, 7, h);
        apply(0, 1, 0, CBZ, 0, 0, 7, h);
        apply(0, 1, 0, BR, 7, 7, 7, h);
        idle(4);
        // unknown opcode is a bubble
        apply(0, 1, 0, BAD, 1, 2, 3, h);
        idle(4);
        // reset mid-stall
        apply(0, 1, 0, LDUR, 2, 0, 1, h);
        apply(0, 1, 0, ADD, 1, 4, 3, h);
        apply(1, 1, 0, ADD, 1, 4, 3, h);
        idle(4);

        hold = 1'b0;
        v = 1'b0; op = '0; rn = 0; rm = 0; rd = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 11) == 0);
            if (!hold) begin
                v  = ($urandom_range(0, 9) != 0);
                op = rand_op();
                rn = rand_reg();
                rm = rand_reg();
                rd = rand_reg();
            end
            apply(r, v, f, op, rn, rm, rd, hold);
        end
        idle(2);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
